// File: rtl/video_pll_supervisor_pkg.sv
// Shared types and sizing helpers for the video PLL supervisor.
package video_pll_pkg;

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        QUALIFY,
        RUN,
        FAIL
    } state_e;

    localparam int DEF_RST_PULSE_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT     = 74250;
    localparam int DEF_STABLE_CYCLES    = 1024;
    localparam int DEF_MAX_RETRIES      = 7;
    localparam int DEF_SYNC_STAGES      = 2;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_pll_supervisor_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/video_pll_supervisor.sv
// Video PLL supervisor: pulses the PLL reset, qualifies lock, releases the
// video domain reset, retries on lock timeout and restarts on core request.
//
// state      | meaning
// ASSERT_RST | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK  | waiting for synchronized lock, attempt timer running
// QUALIFY    | lock seen, counting consecutive locked cycles
// RUN        | lock qualified, video domain out of reset
// FAIL       | retries exhausted; PLL left running so a late lock can recover
module video_pll_supervisor
    import video_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    input  logic       restart_req,
    output logic       restart_ack,
    output logic       video_reset_n,
    output logic       pll_fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int PULSE_W  = cnt_w(RST_PULSE_CYCLES);
    localparam int TIMER_W  = cnt_w(LOCK_TIMEOUT);
    localparam int STABLE_W = cnt_w(STABLE_CYCLES);

    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]          MAX_R       = 3'(MAX_RETRIES);

    state_e              state_q, state_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [2:0]          retry_d;
    logic [7:0]          loss_d;
    logic                fail_d;
    logic                ack_d;
    logic                lk;
    logic                restart_go;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lk)
    );

    // A restart is ignored while a reset pulse is already in flight.
    assign restart_go = restart_req && !restart_ack && (state_q != ASSERT_RST);

    // Next-state, counter and output-register decisions.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        retry_d  = retry_cnt;
        loss_d   = lock_loss_cnt;
        fail_d   = pll_fail;
        ack_d    = restart_ack && restart_req;

        if (restart_go) begin
            state_d = ASSERT_RST;
            pulse_d = '0;
            retry_d = '0;
            fail_d  = 1'b0;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                ASSERT_RST: begin
                    if (pulse_q == PULSE_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                    end
                end
                WAIT_LOCK, QUALIFY: begin
                    if (timer_q == TIMER_LAST) begin
                        if (retry_cnt < MAX_R) begin
                            retry_d = retry_cnt + 3'd1;
                            state_d = ASSERT_RST;
                            pulse_d = '0;
                        end else begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (state_q == WAIT_LOCK) begin
                            if (lk) begin
                                state_d  = QUALIFY;
                                stable_d = '0;
                            end
                        end else if (!lk) begin
                            state_d  = WAIT_LOCK;
                            stable_d = '0;
                        end else if (stable_q == STABLE_LAST) begin
                            state_d = RUN;
                        end else begin
                            stable_d = stable_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                        if (lock_loss_cnt != 8'hFF) begin
                            loss_d = lock_loss_cnt + 8'd1;
                        end
                    end
                end
                FAIL: begin
                    // Late lock gets a fresh timer so it can actually qualify.
                    if (lk) begin
                        state_d  = QUALIFY;
                        stable_d = '0;
                        timer_d  = '0;
                    end
                end
                default: begin
                    state_d = ASSERT_RST;
                    pulse_d = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ASSERT_RST;
            pulse_q       <= '0;
            timer_q       <= '0;
            stable_q      <= '0;
            pll_rst       <= 1'b1;
            video_reset_n <= 1'b0;
            restart_ack   <= 1'b0;
            pll_fail      <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            timer_q       <= timer_d;
            stable_q      <= stable_d;
            pll_rst       <= (state_d == ASSERT_RST);
            video_reset_n <= (state_d == RUN);
            restart_ack   <= ack_d;
            pll_fail      <= fail_d;
            retry_cnt     <= retry_d;
            lock_loss_cnt <= loss_d;
        end
    end

endmodule

// File: tb/tb_video_pll_supervisor.sv
// Bench for video_pll_supervisor: per-cycle scoreboard fed by a reference
// model that tracks deadlines and lock streaks in absolute clock-edge numbers.
module tb_video_pll_supervisor;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 100;
    localparam int STABLE    = 8;
    localparam int MAXR      = 2;
    localparam int SYNC      = 2;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       restart_req;
    logic       restart_ack;
    logic       video_reset_n;
    logic       pll_fail;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int tests = 0;
    int fails = 0;

    video_pll_supervisor #(
        .RST_PULSE_CYCLES (RST_PULSE),
        .LOCK_TIMEOUT     (TIMEOUT),
        .STABLE_CYCLES    (STABLE),
        .MAX_RETRIES      (MAXR),
        .SYNC_STAGES      (SYNC)
    ) dut (
        .clk_74a       (clk_74a),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .restart_req   (restart_req),
        .restart_ack   (restart_ack),
        .video_reset_n (video_reset_n),
        .pll_fail      (pll_fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_74a = ~clk_74a;

    typedef struct packed {
        logic       rst;
        logic       vrn;
        logic       ack;
        logic       fail;
        logic [2:0] retry;
        logic [7:0] loss;
    } outv_t;

    outv_t exp_q[$];

    // Reference model: which phase we are in, plus absolute edge deadlines.
    typedef enum int {M_PULSE, M_SEEK, M_RUN, M_FAIL} mode_t;
    mode_t m_mode;
    int    m_edge, m_pulse_exit, m_deadline, m_streak, m_retry, m_loss;
    bit    m_ack, m_fail;
    bit    lkq[$];

    function automatic outv_t model_out();
        outv_t o;
        o.rst   = (m_mode == M_PULSE);
        o.vrn   = (m_mode == M_RUN);
        o.ack   = m_ack;
        o.fail  = m_fail;
        o.retry = 3'(m_retry);
        o.loss  = 8'(m_loss);
        return o;
    endfunction

    task automatic model_reset();
        m_mode       = M_PULSE;
        m_edge       = 0;
        m_pulse_exit = RST_PULSE;
        m_deadline   = 0;
        m_streak     = 0;
        m_retry      = 0;
        m_loss       = 0;
        m_ack        = 1'b0;
        m_fail       = 1'b0;
        lkq.delete();
        repeat (SYNC) lkq.push_back(1'b0);
    endtask

    task automatic enter_seek(input int streak);
        m_mode     = M_SEEK;
        m_deadline = m_edge + TIMEOUT;
        m_streak   = streak;
    endtask

    task automatic model_step(input bit pin, input bit req);
        bit lk;
        bit nxt_ack;
        lk = lkq.pop_front();
        lkq.push_back(pin);
        m_edge++;
        nxt_ack = m_ack && req;
        if (req && !m_ack && m_mode != M_PULSE) begin
            m_mode       = M_PULSE;
            m_pulse_exit = m_edge + RST_PULSE;
            m_retry      = 0;
            m_fail       = 1'b0;
            nxt_ack      = 1'b1;
        end else begin
            case (m_mode)
                M_PULSE: if (m_edge == m_pulse_exit) enter_seek(0);
                M_SEEK: begin
                    if (m_edge == m_deadline) begin
                        if (m_retry < MAXR) begin
                            m_retry++;
                            m_mode       = M_PULSE;
                            m_pulse_exit = m_edge + RST_PULSE;
                        end else begin
                            m_mode = M_FAIL;
                            m_fail = 1'b1;
                        end
                    end else begin
                        // First locked sample leaves waiting, STABLE more qualify.
                        m_streak = lk ? m_streak + 1 : 0;
                        if (m_streak == STABLE + 1) m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!lk) begin
                        enter_seek(0);
                        if (m_loss < 255) m_loss++;
                    end
                end
                M_FAIL: if (lk) enter_seek(1);
                default: m_mode = M_PULSE;
            endcase
        end
        m_ack = nxt_ack;
    endtask

    // Predict the outputs each edge; a reset replaces any pending prediction.
    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(model_out());
        end else begin
            model_step(pll_locked, restart_req);
            exp_q.push_back(model_out());
        end
    end

    // Monitor: compare the DUT outputs against the oldest prediction.
    always @(negedge clk_74a) begin
        outv_t got;
        outv_t want;
        got = {pll_rst, video_reset_n, restart_ack, pll_fail, retry_cnt, lock_loss_cnt};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at %0t: got outputs %h, want a prediction", $time, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                fails++;
                $display("FAIL outputs at %0t: got rst=%0b vrn=%0b ack=%0b fail=%0b retry=%0d loss=%0d, want rst=%0b vrn=%0b ack=%0b fail=%0b retry=%0d loss=%0d",
                         $time, got.rst, got.vrn, got.ack, got.fail, got.retry, got.loss,
                         want.rst, want.vrn, want.ack, want.fail, want.retry, want.loss);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_74a);
        #1;
    endtask

    initial begin
        int k;
        int lk_hold;
        reset_n     = 1'b0;
        pll_locked  = 1'b0;
        restart_req = 1'b0;
        step(3);
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_vrn", video_reset_n, 0);
        chk("reset_ack", restart_ack, 0);
        chk("reset_fail", pll_fail, 0);

        // Power-up with lock arriving at cycle 10.
        reset_n = 1'b1;
        step(3);
        chk("t1_pulse_last", pll_rst, 1);
        step(1);
        chk("t1_pulse_end", pll_rst, 0);
        step(6);
        pll_locked = 1'b1;
        step(10);
        chk("t1_vrn_before", video_reset_n, 0);
        step(1);
        chk("t1_vrn_rise", video_reset_n, 1);
        chk("t1_retry", retry_cnt, 0);

        // Lock loss in RUN, then a one-cycle glitch during requalification.
        step(3);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        chk("t4_vrn_still_high", video_reset_n, 1);
        step(1);
        chk("t4_vrn_drop", video_reset_n, 0);
        chk("t4_loss_one", lock_loss_cnt, 1);
        chk("t4_no_pulse", pll_rst, 0);
        k = $urandom_range(4, 9);
        step(k - 3);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(10);
        chk("t3_vrn_before", video_reset_n, 0);
        step(1);
        chk("t3_vrn_rise", video_reset_n, 1);
        chk("t3_no_pulse", pll_rst, 0);

        // Many lock losses saturate the counter.
        step(3);
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            step($urandom_range(10, 16));
        end
        chk("t4_loss_sat", lock_loss_cnt, 255);

        // Restart from RUN.
        step(2);
        restart_req = 1'b1;
        step(1);
        chk("t5_ack_set", restart_ack, 1);
        chk("t5_pulse_start", pll_rst, 1);
        step(4);
        chk("t5_pulse_end", pll_rst, 0);
        step(5);
        chk("t5_no_second_pulse", pll_rst, 0);
        chk("t5_ack_held", restart_ack, 1);
        restart_req = 1'b0;
        step(1);
        chk("t5_ack_clear", restart_ack, 0);

        // Drive into FAIL, then restart from there.
        pll_locked = 1'b0;
        for (int i = 0; i < 600 && !pll_fail; i++) step(1);
        chk("t5_reach_fail", pll_fail, 1);
        chk("t5_fail_no_rst", pll_rst, 0);
        chk("t5_fail_retry", retry_cnt, 2);
        restart_req = 1'b1;
        step(1);
        chk("t5_fail_cleared", pll_fail, 0);
        chk("t5_fail_ack", restart_ack, 1);
        chk("t5_retry_cleared", retry_cnt, 0);
        restart_req = 1'b0;
        step(1);
        pll_locked = 1'b1;

        // Asynchronous reset in the middle of qualification.
        step(7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_pll_rst", pll_rst, 1);
        chk("t6_vrn", video_reset_n, 0);
        chk("t6_loss", lock_loss_cnt, 0);
        chk("t6_retry", retry_cnt, 0);
        pll_locked = 1'b0;
        step(2);

        // No lock at all: three pulses, then FAIL.
        reset_n = 1'b1;
        step(103);
        chk("t2_retry0", retry_cnt, 0);
        chk("t2_wait_no_rst", pll_rst, 0);
        step(1);
        chk("t2_retry1", retry_cnt, 1);
        chk("t2_pulse2", pll_rst, 1);
        step(3);
        chk("t2_pulse2_last", pll_rst, 1);
        step(1);
        chk("t2_pulse2_end", pll_rst, 0);
        step(100);
        chk("t2_retry2", retry_cnt, 2);
        chk("t2_pulse3", pll_rst, 1);
        step(103);
        chk("t2_not_failed", pll_fail, 0);
        step(1);
        chk("t2_failed", pll_fail, 1);
        chk("t2_fail_rst", pll_rst, 0);
        chk("t2_fail_vrn", video_reset_n, 0);

        // Random soak: lock wander and restart requests.
        lk_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lk_hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                lk_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                       : int'($urandom_range(5, 120));
            end
            lk_hold--;
            if ($urandom_range(0, 49) == 0) restart_req = ~restart_req;
            step(1);
        end
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
